// File: rtl/game_pkg.sv
// Shared game constants: state encodings, screen/ball geometry and the initial brick map.
package game_pkg;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_OVER  = 3'd3,
        ST_WIN   = 3'd4
    } game_state_t;

    localparam int H       = 640;
    localparam int V       = 480;
    localparam int BALL_W  = 16;
    localparam int BALL_H  = 10;
    localparam int BOARD_Y = 467;
    localparam int LOSS_Y  = 530;

    localparam int N_CELLS = 480;
    localparam int CELL_W  = 3;
    localparam int BRICK_W = N_CELLS * CELL_W;

    // Ball rests on the paddle while serving, offset to sit near the paddle centre.
    localparam logic [9:0] SERVE_DX = 10'd40;
    localparam logic [9:0] SERVE_Y  = 10'(BOARD_Y - BALL_H - 2);

    // Every cell starts as a single-hit brick.
    localparam logic [BRICK_W-1:0] BRICKS_INIT = {N_CELLS{3'b001}};

endpackage

// File: rtl/score_acc.sv
// Saturating score adder; binary by default, 4-digit packed BCD when
// GAME_UPDATE_BCD_SCORE_EN is defined.
module score_acc
    import game_pkg::*;
(
    input  logic [15:0] acc,
    input  logic [3:0]  inc,
    output logic [15:0] result
);

`ifdef GAME_UPDATE_BCD_SCORE_EN
    logic [4:0]  carry [0:4];
    logic [15:0] digits;

    assign carry[0] = {1'b0, inc};

    // Digit 0 can receive up to 15, so its carry-out may be 2; higher digits carry at most 1.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [4:0] digit_sum;
            assign digit_sum            = {1'b0, acc[4*gi +: 4]} + carry[gi];
            assign digits[4*gi +: 4]    = 4'(digit_sum % 5'd10);
            assign carry[gi+1]          = digit_sum / 5'd10;
        end
    endgenerate

    assign result = (carry[4] != 5'd0) ? 16'h9999 : digits;
`else
    logic [16:0] bin_sum;

    assign bin_sum = {1'b0, acc} + {13'd0, inc};
    assign result  = bin_sum[16] ? 16'hFFFF : bin_sum[15:0];
`endif

endmodule

// File: rtl/game_update.sv
// Per-frame game state update: menu/serve/play/over/win control plus registered ball,
// brick map, score and lives. Score format selected by GAME_UPDATE_BCD_SCORE_EN.
module game_update
    import game_pkg::*;
#(
    parameter int         LIVES_INIT = 3,
    parameter logic [9:0] SERVE_V    = 10'd4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                start_btn,
    input  logic                launch_btn,
    input  logic [9:0]          board_x,
    input  logic [BRICK_W-1:0]  next_bricks,
    input  logic [9:0]          next_ball_x,
    input  logic [9:0]          next_ball_y,
    input  logic [9:0]          next_ball_vx,
    input  logic [9:0]          next_ball_vy,
    input  logic [1:0]          next_ball_dir,
    input  logic [3:0]          collision_trig,
    output logic [BRICK_W-1:0]  bricks,
    output logic [9:0]          ball_x,
    output logic [9:0]          ball_y,
    output logic [9:0]          ball_vx,
    output logic [9:0]          ball_vy,
    output logic [1:0]          ball_dir,
    output logic [2:0]          state,
    output logic [15:0]         score,
    output logic [1:0]          lives
);

    game_state_t        state_reg, state_next;
    logic [BRICK_W-1:0] bricks_reg, bricks_next;
    logic [9:0]         ball_x_reg, ball_x_next;
    logic [9:0]         ball_y_reg, ball_y_next;
    logic [9:0]         ball_vx_reg, ball_vx_next;
    logic [9:0]         ball_vy_reg, ball_vy_next;
    logic [1:0]         ball_dir_reg, ball_dir_next;
    logic [15:0]        score_reg, score_next;
    logic [1:0]         lives_reg, lives_next;

    logic [15:0] score_sum;
    logic [10:0] loss_sum;
    logic        ball_lost;

    score_acc u_score_acc (
        .acc    (score_reg),
        .inc    (collision_trig),
        .result (score_sum)
    );

    // Loss test uses the current registered ball, wrapping naturally at 11 bits.
    assign loss_sum  = {1'b0, ball_y_reg} + {1'b0, ball_vy_reg} + 11'd10;
    assign ball_lost = ball_dir_reg[0] && (loss_sum > 11'(LOSS_Y));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_MENU;
            bricks_reg   <= '0;
            ball_x_reg   <= '0;
            ball_y_reg   <= '0;
            ball_vx_reg  <= '0;
            ball_vy_reg  <= '0;
            ball_dir_reg <= '0;
            score_reg    <= '0;
            lives_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            bricks_reg   <= bricks_next;
            ball_x_reg   <= ball_x_next;
            ball_y_reg   <= ball_y_next;
            ball_vx_reg  <= ball_vx_next;
            ball_vy_reg  <= ball_vy_next;
            ball_dir_reg <= ball_dir_next;
            score_reg    <= score_next;
            lives_reg    <= lives_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bricks_next   = bricks_reg;
        ball_x_next   = ball_x_reg;
        ball_y_next   = ball_y_reg;
        ball_vx_next  = ball_vx_reg;
        ball_vy_next  = ball_vy_reg;
        ball_dir_next = ball_dir_reg;
        score_next    = score_reg;
        lives_next    = lives_reg;

        case (state_reg)
            ST_MENU: begin
                if (start_btn) begin
                    bricks_next = BRICKS_INIT;
                    score_next  = '0;
                    lives_next  = 2'(LIVES_INIT);
                    state_next  = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    ball_x_next   = board_x + SERVE_DX;
                    ball_y_next   = SERVE_Y;
                    ball_vx_next  = SERVE_V;
                    ball_vy_next  = SERVE_V;
                    ball_dir_next = 2'b10;
                end
                if (launch_btn) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    bricks_next   = next_bricks;
                    ball_x_next   = next_ball_x;
                    ball_y_next   = next_ball_y;
                    ball_vx_next  = next_ball_vx;
                    ball_vy_next  = next_ball_vy;
                    ball_dir_next = next_ball_dir;
                    score_next    = score_sum;
                    // Clearing the last brick wins even if the ball is lost on the same frame.
                    if (next_bricks == '0) begin
                        state_next = ST_WIN;
                    end else if (ball_lost) begin
                        if (lives_reg > 2'd1) begin
                            lives_next = lives_reg - 2'd1;
                            state_next = ST_SERVE;
                        end else begin
                            lives_next = 2'd0;
                            state_next = ST_OVER;
                        end
                    end
                end
            end
            ST_OVER, ST_WIN: begin
                if (start_btn) begin
                    state_next = ST_MENU;
                end
            end
            default: state_next = ST_MENU;
        endcase
    end

    assign state    = state_reg;
    assign bricks   = bricks_reg;
    assign ball_x   = ball_x_reg;
    assign ball_y   = ball_y_reg;
    assign ball_vx  = ball_vx_reg;
    assign ball_vy  = ball_vy_reg;
    assign ball_dir = ball_dir_reg;
    assign score    = score_reg;
    assign lives    = lives_reg;

endmodule

// File: tb/tb_game_update.sv
// Directed scoreboard bench for game_update: expected snapshots are queued after each
// stimulus step and compared by an independent monitor on the following falling edge.
module tb_game_update;
    import game_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                frame_tick;
    logic                start_btn;
    logic                launch_btn;
    logic [9:0]          board_x;
    logic [BRICK_W-1:0]  next_bricks;
    logic [9:0]          next_ball_x, next_ball_y, next_ball_vx, next_ball_vy;
    logic [1:0]          next_ball_dir;
    logic [3:0]          collision_trig;
    logic [BRICK_W-1:0]  bricks;
    logic [9:0]          ball_x, ball_y, ball_vx, ball_vy;
    logic [1:0]          ball_dir;
    logic [2:0]          state;
    logic [15:0]         score;
    logic [1:0]          lives;

    typedef struct {
        string              name;
        logic [2:0]         st;
        logic [9:0]         bx, by, vx, vy;
        logic [1:0]         dir;
        logic [15:0]        score;
        logic [1:0]         lives;
        logic [BRICK_W-1:0] bricks;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   checks   = 0;
    int   failures = 0;

    logic [BRICK_W-1:0] bi;
    logic [BRICK_W-1:0] nb1;

`ifdef GAME_UPDATE_BCD_SCORE_EN
    localparam logic [15:0] SC4 [0:3] = '{16'h0003, 16'h0006, 16'h0009, 16'h0012};
    localparam int          SAT_LOOPS = 666;
    localparam logic [3:0]  SAT_REM   = 4'd7;
    localparam logic [15:0] NEAR_MAX  = 16'h9997;
    localparam logic [3:0]  LAST_ADD  = 4'd5;
    localparam logic [15:0] SAT_VAL   = 16'h9999;
`else
    localparam logic [15:0] SC4 [0:3] = '{16'd3, 16'd6, 16'd9, 16'd12};
    localparam int          SAT_LOOPS = 4368;
    localparam logic [3:0]  SAT_REM   = 4'd14;
    localparam logic [15:0] NEAR_MAX  = 16'hFFFE;
    localparam logic [3:0]  LAST_ADD  = 4'd7;
    localparam logic [15:0] SAT_VAL   = 16'hFFFF;
`endif

    game_update dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_tick     (frame_tick),
        .start_btn      (start_btn),
        .launch_btn     (launch_btn),
        .board_x        (board_x),
        .next_bricks    (next_bricks),
        .next_ball_x    (next_ball_x),
        .next_ball_y    (next_ball_y),
        .next_ball_vx   (next_ball_vx),
        .next_ball_vy   (next_ball_vy),
        .next_ball_dir  (next_ball_dir),
        .collision_trig (collision_trig),
        .bricks         (bricks),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .ball_vx        (ball_vx),
        .ball_vy        (ball_vy),
        .ball_dir       (ball_dir),
        .state          (state),
        .score          (score),
        .lives          (lives)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic tick, input logic start, input logic launch);
        @(negedge clk);
        frame_tick = tick;
        start_btn  = start;
        launch_btn = launch;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        launch_btn = 1'b0;
    endtask

    task automatic chk(input string name);
        exp_t e;
        e      = m;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic set_next(input logic [9:0] x, input logic [9:0] y, input logic [9:0] vx,
                            input logic [9:0] vy, input logic [1:0] dir);
        next_ball_x   = x;
        next_ball_y   = y;
        next_ball_vx  = vx;
        next_ball_vy  = vy;
        next_ball_dir = dir;
    endtask

    task automatic m_latch();
        m.bx     = next_ball_x;
        m.by     = next_ball_y;
        m.vx     = next_ball_vx;
        m.vy     = next_ball_vy;
        m.dir    = next_ball_dir;
        m.bricks = next_bricks;
    endtask

    task automatic m_serve(input logic [9:0] bx);
        m.bx  = bx;
        m.by  = 10'd455;
        m.vx  = 10'd4;
        m.vy  = 10'd4;
        m.dir = 2'b10;
    endtask

    task automatic m_zero();
        m.st = 3'd0; m.bx = '0; m.by = '0; m.vx = '0; m.vy = '0;
        m.dir = '0; m.score = '0; m.lives = '0; m.bricks = '0;
    endtask

    // Monitor: pops one expected snapshot per falling edge whenever one is pending.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                ok = (state === e.st) && (ball_x === e.bx) && (ball_y === e.by) &&
                     (ball_vx === e.vx) && (ball_vy === e.vy) && (ball_dir === e.dir) &&
                     (score === e.score) && (lives === e.lives) && (bricks === e.bricks);
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL %s: got st=%0d x=%0d y=%0d vx=%0d vy=%0d dir=%b score=%h lives=%0d bricks_ok=%0b ; want st=%0d x=%0d y=%0d vx=%0d vy=%0d dir=%b score=%h lives=%0d",
                             e.name, state, ball_x, ball_y, ball_vx, ball_vy, ball_dir, score, lives,
                             bricks === e.bricks, e.st, e.bx, e.by, e.vx, e.vy, e.dir, e.score, e.lives);
                end else begin
                    $display("ok   %s: st=%0d x=%0d y=%0d score=%h lives=%0d", e.name, state, ball_x,
                             ball_y, score, lives);
                end
            end
        end
    end

    initial begin
        bi  = BRICKS_INIT;
        nb1 = BRICKS_INIT ^ {{(BRICK_W-3){1'b0}}, 3'b111};
        rst_n = 1'b0;
        frame_tick = 1'b0; start_btn = 1'b0; launch_btn = 1'b0;
        board_x = 10'd100;
        next_bricks = nb1;
        set_next(10'd777, 10'd777, 10'd777, 10'd777, 2'b01);
        collision_trig = 4'd9;

        m_zero();
        chk("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step(1'b0, 1'b0, 1'b1); chk("menu_launch_ignored");
        step(1'b1, 1'b0, 1'b0); chk("menu_tick_idle");
        step(1'b0, 1'b1, 1'b0);
        m.st = 3'd1; m.bricks = bi; m.score = 16'd0; m.lives = 2'd3;
        chk("start");
        step(1'b1, 1'b0, 1'b0); m_serve(10'd140); chk("serve_tick");
        step(1'b1, 1'b0, 1'b0); chk("serve_ignores_next");
        step(1'b0, 1'b0, 1'b1); m.st = 3'd2; chk("launch");

        set_next(10'd200, 10'd300, 10'd5, 10'd6, 2'b10);
        collision_trig = 4'd3;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b0);
            m_latch(); m.score = SC4[k];
            chk($sformatf("play_score_%0d", k));
        end

        set_next(10'd300, 10'd100, 10'd5, 10'd6, 2'b10);
        collision_trig = 4'd5;
        step(1'b0, 1'b0, 1'b0); chk("no_tick_hold");

        collision_trig = 4'd0;
        set_next(10'd300, 10'd512, 10'd5, 10'd8, 2'b11);
        step(1'b1, 1'b0, 1'b0); m_latch(); chk("latch_down");
        step(1'b1, 1'b0, 1'b0); m_latch(); chk("edge_530_no_loss");
        set_next(10'd300, 10'd515, 10'd5, 10'd8, 2'b11);
        step(1'b1, 1'b0, 1'b0); m_latch(); chk("latch_515");
        step(1'b1, 1'b0, 1'b0); m_latch(); m.lives = 2'd2; m.st = 3'd1; chk("loss_to_serve");

        board_x = 10'd50;
        step(1'b1, 1'b0, 1'b0); m_serve(10'd90); chk("serve_board50");
        step(1'b0, 1'b0, 1'b1); m.st = 3'd2; chk("launch2");
        step(1'b1, 1'b0, 1'b0); m_latch(); chk("latch_again");
        step(1'b1, 1'b0, 1'b0); m_latch(); m.lives = 2'd1; m.st = 3'd1; chk("loss_lives1");
        step(1'b0, 1'b0, 1'b1); m.st = 3'd2; chk("launch3");
        step(1'b1, 1'b0, 1'b0); m_latch(); m.lives = 2'd0; m.st = 3'd3; chk("loss_to_over");

        set_next(10'd1, 10'd2, 10'd3, 10'd4, 2'b00);
        collision_trig = 4'd7;
        step(1'b1, 1'b0, 1'b0); chk("over_frozen");
        step(1'b1, 1'b0, 1'b1); chk("over_launch_ignored");
        step(1'b0, 1'b1, 1'b0); m.st = 3'd0; chk("over_to_menu_score_held");

        step(1'b0, 1'b1, 1'b0);
        m.st = 3'd1; m.bricks = bi; m.score = 16'd0; m.lives = 2'd3;
        chk("restart");
        board_x = 10'd100;
        step(1'b1, 1'b0, 1'b0); m_serve(10'd140); chk("serve_restart");
        step(1'b0, 1'b0, 1'b1); m.st = 3'd2;
        collision_trig = 4'd0;
        set_next(10'd300, 10'd515, 10'd5, 10'd8, 2'b11);
        step(1'b1, 1'b0, 1'b0); m_latch(); chk("latch_before_win");
        next_bricks = '0;
        step(1'b1, 1'b0, 1'b0); m_latch(); m.st = 3'd4; chk("win_priority_over_loss");
        next_bricks = nb1;
        step(1'b1, 1'b0, 1'b0); chk("win_frozen");

        step(1'b0, 1'b1, 1'b0); m.st = 3'd0;
        step(1'b0, 1'b1, 1'b0);
        m.st = 3'd1; m.bricks = bi; m.score = 16'd0; m.lives = 2'd3;
        step(1'b1, 1'b0, 1'b0); m_serve(10'd140);
        step(1'b0, 1'b0, 1'b1); m.st = 3'd2;
        chk("restart_after_win");
        set_next(10'd200, 10'd300, 10'd5, 10'd6, 2'b10);
        collision_trig = 4'd15;
        for (int k = 0; k < SAT_LOOPS; k++) step(1'b1, 1'b0, 1'b0);
        collision_trig = SAT_REM;
        step(1'b1, 1'b0, 1'b0); m_latch(); m.bricks = nb1; m.score = NEAR_MAX; chk("score_near_max");
        collision_trig = LAST_ADD;
        step(1'b1, 1'b0, 1'b0); m.score = SAT_VAL; chk("score_saturate");
        collision_trig = 4'd15;
        step(1'b1, 1'b0, 1'b0); chk("score_saturate_hold");

        @(posedge clk);
        #2 rst_n = 1'b0;
        m_zero();
        chk("async_reset_mid_play");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0); chk("menu_after_reset");
        step(1'b0, 1'b0, 1'b1); chk("launch_ignored_after_reset");
        step(1'b0, 1'b1, 1'b0);
        m.st = 3'd1; m.bricks = bi; m.lives = 2'd3;
        chk("start_after_reset");

        for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected snapshots never compared, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_update.md
GAME_UPDATE -- requirements
Module: game_update

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, meaning lives loaded on game start (1..3).
REQ-002 SHALL have parameter SERVE_V, default 10'd4, meaning vx and vy loaded at serve.
REQ-003 SHALL have clk  input  1  system clock; one clock, all state on rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have frame_tick  input  1  one-cycle pulse; game update strobe.
REQ-006 SHALL have start_btn, launch_btn  input  1 each  debounced single-cycle pulses.
REQ-007 SHALL have board_x  input  10  paddle left x.
REQ-008 SHALL have next_bricks  input  1440  next brick map, 480 cells x 3 bits.
REQ-009 SHALL have next_ball_x, next_ball_y, next_ball_vx, next_ball_vy  input  10 each  next ball state.
REQ-010 SHALL have next_ball_dir  input  2  next direction, bit1 = right, bit0 = down.
REQ-011 SHALL have collision_trig  input  4  brick hit points this update.
REQ-012 SHALL have bricks  output  1440  registered brick map.
REQ-013 SHALL have ball_x, ball_y, ball_vx, ball_vy  output  10 each  registered ball state.
REQ-014 SHALL have ball_dir  output  2  registered direction.
REQ-015 SHALL have state  output  3  game state.
REQ-016 SHALL have score  output  16  score; lives  output  2  remaining lives.

Function
REQ-017 SHALL encode state as MENU=0, SERVE=1, PLAY=2, OVER=3, WIN=4; all other codes go to MENU on the next clock.
REQ-018 SHALL change outputs only on the clock edge where frame_tick=1, except button-driven transitions, which take effect on the edge after the pulse.
REQ-019 In MENU, on start_btn: SHALL load bricks=BRICKS_INIT, score=0, lives=LIVES_INIT, and go to SERVE.
REQ-020 In SERVE, on each frame_tick: SHALL hold ball_x=board_x+40, ball_y=455, ball_vx=ball_vy=SERVE_V, ball_dir=2'b10, and ignore next_* inputs.
REQ-021 In SERVE, on launch_btn: SHALL go to PLAY with no other state change.
REQ-022 In PLAY, on frame_tick: SHALL latch all next_* values into the registered outputs and add zero-extended collision_trig to score, saturating at 16'hFFFF.
REQ-023 Ball loss SHALL be asserted in PLAY on frame_tick when ball_dir[0]=1 and ball_y+ball_vy+10 > 530, computed in 11-bit arithmetic on the registered values.
REQ-024 On ball loss: if lives>1, SHALL decrement lives and go to SERVE; if lives=1, SHALL set lives=0 and go to OVER.
REQ-025 If next_bricks==0 on the same PLAY tick as a loss, WIN SHALL take priority and lives SHALL remain unchanged.
REQ-026 In OVER or WIN, SHALL freeze all outputs; start_btn SHALL return to MENU with score held.
REQ-027 start_btn and launch_btn SHALL be ignored in states where they are not listed above.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=MENU, bricks=0, ball_x=0, ball_y=0, ball_vx=0, ball_vy=0, ball_dir=0, score=0, lives=0.
REQ-029 Reset asserted mid-frame SHALL discard any pending update; the first tick after release SHALL see MENU behaviour.

Configuration
REQ-030 With macro GAME_UPDATE_BCD_SCORE_EN defined, score SHALL be 4-digit packed BCD: each update adds collision_trig with per-digit carry, saturating at 16'h9999.
REQ-031 Without GAME_UPDATE_BCD_SCORE_EN, score SHALL be binary, per REQ-022.

Structure
REQ-032 A shared package game_pkg SHALL hold: the state encodings, BRICKS_INIT, H=640, V=480, BALL_W=16, BALL_H=10, BOARD_Y=467, LOSS_Y=530.
REQ-033 The score adder SHALL be the single sub-module score_acc (binary or BCD, per the macro).

Verification
REQ-034 Reset, then start_btn, then tick with board_x=100 -> state=1, ball_x=140, ball_y=455, lives=3, bricks=BRICKS_INIT.
REQ-035 In PLAY, collision_trig=3 on each of 4 ticks -> score=12 (binary) or 16'h0012 (BCD).
REQ-036 In PLAY with lives=1, ball_y=515, vy=8, dir=2'b11, tick -> state=3, lives=0, outputs frozen on later ticks.
REQ-037 Loss and next_bricks=0 on the same tick -> state=4, lives unchanged.
REQ-038 score=16'hFFFE with collision_trig=7 -> 16'hFFFF; under the BCD macro, 16'h9997 with 5 -> 16'h9999.
REQ-039 rst_n pulsed low mid-PLAY between ticks -> all outputs at reset values asynchronously; launch_btn ignored in MENU.
